// File: rtl/nim_pulse_pkg.sv
// Shared types and default widths for the multi-channel NIM pulse generator.
package nim_pulse_pkg;

  localparam int N_CH_DEF     = 4;
  localparam int PERIOD_W_DEF = 16;
  localparam int LENGTH_W_DEF = 6;
  localparam int BURST_W_DEF  = 8;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    TRIG = 2'd1,
    GATE = 2'd2,
    RSVD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } chan_state_t;

endpackage

// File: rtl/nim_pulse_chan.sv
// One pulse-generator channel: start detection, shadow configuration, delay/period
// counters and the IDLE/DELAY/HIGH/LOW sequencer. State is exported for observation.
import nim_pulse_pkg::*;

module nim_pulse_chan #(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int LENGTH_W = LENGTH_W_DEF,
  parameter int BURST_W  = BURST_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [LENGTH_W-1:0] length,
  input  logic [PERIOD_W-1:0] delay,
  input  logic [BURST_W-1:0]  burst_count,
  input  logic                trigger,
  input  logic                abort,
  output logic                dout,
  output logic                done,
  output chan_state_t         state
);

  localparam logic [PERIOD_W:0]  CNT_ONE   = {{PERIOD_W{1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  chan_state_t         state_nxt;
  mode_t               mode_s, mode_nxt;
  logic [PERIOD_W-1:0] period_s, period_nxt;
  logic [PERIOD_W-1:0] delay_s, delay_nxt;
  logic [LENGTH_W-1:0] length_s, length_nxt;
  logic [BURST_W-1:0]  burst_s, burst_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic [BURST_W-1:0]  pulse_cnt, pulse_nxt, pulse_inc;
  logic [PERIOD_W:0]   cnt_inc, length_ext;
  logic                trig_q, gate_stop, gate_stop_nxt;
  logic                start, done_nxt;

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_s;
    period_nxt    = period_s;
    delay_nxt     = delay_s;
    length_nxt    = length_s;
    burst_nxt     = burst_s;
    cnt_nxt       = cnt;
    pulse_nxt     = pulse_cnt;
    done_nxt      = 1'b0;
    start         = 1'b0;
    cnt_inc       = {1'b0, cnt} + CNT_ONE;
    pulse_inc     = pulse_cnt + BURST_ONE;
    length_ext    = {{(PERIOD_W + 1 - LENGTH_W){1'b0}}, length_s};
    // A gated run remembers any low trigger so the current period still completes.
    gate_stop_nxt = gate_stop | ((mode_s == GATE) & ~trigger);

    case (mode_t'(mode))
      FREE:    start = 1'b1;
      TRIG:    start = trigger & ~trig_q;
      GATE:    start = trigger;
      default: start = 1'b0;
    endcase

    if (!enable || abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pulse_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          gate_stop_nxt = 1'b0;
          if (start) begin
            mode_nxt   = mode_t'(mode);
            period_nxt = period;
            delay_nxt  = delay;
            length_nxt = length;
            burst_nxt  = burst_count;
            cnt_nxt    = '0;
            pulse_nxt  = '0;
            if (delay != '0)       state_nxt = DELAY;
            else if (length != '0) state_nxt = HIGH;
            else                   state_nxt = LOW;
          end
        end
        DELAY: begin
          if (cnt_inc == {1'b0, delay_s}) begin
            cnt_nxt   = '0;
            state_nxt = (length_s != '0) ? HIGH : LOW;
          end else begin
            cnt_nxt = cnt_inc[PERIOD_W-1:0];
          end
        end
        HIGH, LOW: begin
          if (cnt == period_s) begin
            cnt_nxt   = '0;
            pulse_nxt = pulse_inc;
            if ((burst_s != '0) && (pulse_inc == burst_s)) begin
              state_nxt = IDLE;
              done_nxt  = (mode_s != GATE);
            end else if ((mode_s == GATE) && gate_stop_nxt) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = (length_s != '0) ? HIGH : LOW;
            end
          end else begin
            cnt_nxt = cnt_inc[PERIOD_W-1:0];
            if ((state == HIGH) && (cnt_inc == length_ext)) state_nxt = LOW;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_s    <= FREE;
      period_s  <= '0;
      delay_s   <= '0;
      length_s  <= '0;
      burst_s   <= '0;
      cnt       <= '0;
      pulse_cnt <= '0;
      trig_q    <= 1'b0;
      gate_stop <= 1'b0;
      dout      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_s    <= mode_nxt;
      period_s  <= period_nxt;
      delay_s   <= delay_nxt;
      length_s  <= length_nxt;
      burst_s   <= burst_nxt;
      cnt       <= cnt_nxt;
      pulse_cnt <= pulse_nxt;
      trig_q    <= trigger;
      gate_stop <= gate_stop_nxt;
      dout      <= (state_nxt == HIGH);
      done      <= done_nxt;
    end
  end

endmodule

// File: rtl/nim_pulse_gen_mc.sv
// Multi-channel NIM pulse generator: N_CH independent channels on flattened
// per-channel configuration buses.
import nim_pulse_pkg::*;

module nim_pulse_gen_mc #(
  parameter int N_CH     = N_CH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int LENGTH_W = LENGTH_W_DEF,
  parameter int BURST_W  = BURST_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            enable,
  input  logic [2*N_CH-1:0]          mode,
  input  logic [N_CH*PERIOD_W-1:0]   period,
  input  logic [N_CH*LENGTH_W-1:0]   length,
  input  logic [N_CH*PERIOD_W-1:0]   delay,
  input  logic [N_CH*BURST_W-1:0]    burst_count,
  input  logic [N_CH-1:0]            trigger,
  input  logic [N_CH-1:0]            abort,
  output logic [N_CH-1:0]            dout,
  output logic [N_CH-1:0]            busy,
  output logic [N_CH-1:0]            done
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_state_t ch_state;

    nim_pulse_chan #(
      .PERIOD_W (PERIOD_W),
      .LENGTH_W (LENGTH_W),
      .BURST_W  (BURST_W)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable[i]),
      .mode        (mode[2*i +: 2]),
      .period      (period[i*PERIOD_W +: PERIOD_W]),
      .length      (length[i*LENGTH_W +: LENGTH_W]),
      .delay       (delay[i*PERIOD_W +: PERIOD_W]),
      .burst_count (burst_count[i*BURST_W +: BURST_W]),
      .trigger     (trigger[i]),
      .abort       (abort[i]),
      .dout        (dout[i]),
      .done        (done[i]),
      .state       (ch_state)
    );

    assign busy[i] = (ch_state != IDLE);
  end

endmodule

// File: tb/tb_nim_pulse_gen_mc.sv
// Bench for nim_pulse_gen_mc: directed scenarios plus randomized multi-channel traffic,
// all checked cycle by cycle against an elapsed-time reference model.
module tb_nim_pulse_gen_mc;

  localparam int N_CH     = 4;
  localparam int PERIOD_W = 16;
  localparam int LENGTH_W = 6;
  localparam int BURST_W  = 8;
  localparam int W        = 3 * N_CH;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic [N_CH-1:0]          enable, trigger, abort;
  logic [2*N_CH-1:0]        mode;
  logic [N_CH*PERIOD_W-1:0] period, delay;
  logic [N_CH*LENGTH_W-1:0] length;
  logic [N_CH*BURST_W-1:0]  burst_count;
  logic [N_CH-1:0]          dout, busy, done;

  nim_pulse_gen_mc #(
    .N_CH(N_CH), .PERIOD_W(PERIOD_W), .LENGTH_W(LENGTH_W), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .period(period),
    .length(length), .delay(delay), .burst_count(burst_count), .trigger(trigger),
    .abort(abort), .dout(dout), .busy(busy), .done(done)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model: a run is described by elapsed cycles since its start event
  bit m_act[N_CH];
  bit m_stop[N_CH];
  bit m_tprev[N_CH];
  int m_e[N_CH], m_per[N_CH], m_len[N_CH], m_dly[N_CH], m_bst[N_CH], m_mode[N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_act[c] = 0; m_stop[c] = 0; m_tprev[c] = 0; m_e[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N_CH-1:0] ed, eb, edn;
    ed = '0; eb = '0; edn = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!reset_n) begin
        m_act[c] = 0; m_stop[c] = 0; m_tprev[c] = 0;
      end else begin
        bit trig, go, stop_now, fin;
        int pos, md;
        trig = trigger[c];
        md   = int'(mode[2*c +: 2]);
        go   = (md == 0) || (md == 1 && trig && !m_tprev[c]) || (md == 2 && trig);
        if (!m_act[c]) begin
          if (enable[c] && !abort[c] && go) begin
            m_act[c]  = 1; m_e[c] = 1; m_stop[c] = 0; m_mode[c] = md;
            m_per[c]  = int'(period[c*PERIOD_W +: PERIOD_W]);
            m_dly[c]  = int'(delay[c*PERIOD_W +: PERIOD_W]);
            m_len[c]  = int'(length[c*LENGTH_W +: LENGTH_W]);
            m_bst[c]  = int'(burst_count[c*BURST_W +: BURST_W]);
          end
        end else if (!enable[c] || abort[c]) begin
          m_act[c] = 0;
        end else begin
          stop_now  = m_stop[c] || (m_mode[c] == 2 && !trig);
          m_stop[c] = stop_now;
          fin = 0;
          if (m_e[c] > m_dly[c]) begin
            pos = m_e[c] - m_dly[c] - 1;
            if (pos % (m_per[c] + 1) == m_per[c]) begin
              if (m_bst[c] != 0 && pos / (m_per[c] + 1) + 1 == m_bst[c]) begin
                fin = 1;
                edn[c] = (m_mode[c] != 2);
              end else if (m_mode[c] == 2 && stop_now) begin
                fin = 1;
              end
            end
          end
          if (fin) m_act[c] = 0;
          else     m_e[c]++;
        end
        m_tprev[c] = trig;
        if (m_act[c]) begin
          eb[c] = 1'b1;
          if (m_e[c] > m_dly[c] && ((m_e[c] - m_dly[c] - 1) % (m_per[c] + 1)) < m_len[c])
            ed[c] = 1'b1;
        end
      end
    end
    exp_q.push_back({ed, eb, edn});
  endtask

  // per-window observation statistics
  int sample;
  int hi_cnt[N_CH], rise_cnt[N_CH], done_cnt[N_CH], first_hi[N_CH], last_busy[N_CH];
  logic [N_CH-1:0] prev_dout;

  task automatic clr_stats();
    sample = 0;
    prev_dout = dout;
    for (int c = 0; c < N_CH; c++) begin
      hi_cnt[c] = 0; rise_cnt[c] = 0; done_cnt[c] = 0; first_hi[c] = 0; last_busy[c] = 0;
    end
  endtask

  // driver: inputs are set just after a falling edge, outputs checked on the next one
  task automatic run_cycles(input int n);
    logic [W-1:0] e;
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      sample++;
      e = exp_q.pop_front();
      check($sformatf("dout@%0d", sample), 32'(dout), 32'(e[3*N_CH-1:2*N_CH]));
      check($sformatf("busy@%0d", sample), 32'(busy), 32'(e[2*N_CH-1:N_CH]));
      check($sformatf("done@%0d", sample), 32'(done), 32'(e[N_CH-1:0]));
      for (int c = 0; c < N_CH; c++) begin
        if (dout[c]) hi_cnt[c]++;
        if (dout[c] && !prev_dout[c]) rise_cnt[c]++;
        if (done[c]) done_cnt[c]++;
        if (busy[c]) last_busy[c] = sample;
        if (dout[c] && first_hi[c] == 0) first_hi[c] = sample;
      end
      prev_dout = dout;
    end
  endtask

  task automatic set_cfg(input int c, input int md, input int per, input int len,
                         input int dly, input int bst);
    mode[2*c +: 2]                     = 2'(md);
    period[c*PERIOD_W +: PERIOD_W]     = PERIOD_W'(per);
    length[c*LENGTH_W +: LENGTH_W]     = LENGTH_W'(len);
    delay[c*PERIOD_W +: PERIOD_W]      = PERIOD_W'(dly);
    burst_count[c*BURST_W +: BURST_W]  = BURST_W'(bst);
  endtask

  task automatic async_reset_check(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    run_cycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    enable = '0; trigger = '0; abort = '0;
    mode = '0; period = '0; length = '0; delay = '0; burst_count = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    run_cycles(3);

    // free-running, 3 high / 7 low
    set_cfg(0, 0, 9, 3, 0, 0);
    enable[0] = 1'b1;
    clr_stats();
    run_cycles(40);
    check("free_hi", 32'(hi_cnt[0]), 32'd12);
    check("free_rises", 32'(rise_cnt[0]), 32'd4);
    check("free_done", 32'(done_cnt[0]), 32'd0);
    enable[0] = 1'b0;
    run_cycles(3);

    // triggered burst with delay
    set_cfg(1, 1, 4, 2, 5, 3);
    enable[1] = 1'b1;
    run_cycles(2);
    trigger[1] = 1'b1;
    clr_stats();
    run_cycles(30);
    check("trig_first_hi", 32'(first_hi[1]), 32'd6);
    check("trig_hi", 32'(hi_cnt[1]), 32'd6);
    check("trig_rises", 32'(rise_cnt[1]), 32'd3);
    check("trig_done", 32'(done_cnt[1]), 32'd1);
    check("trig_busy_end", 32'(last_busy[1]), 32'd20);
    trigger[1] = 1'b0;
    enable[1] = 1'b0;
    run_cycles(2);

    // retrigger mid-burst is ignored
    set_cfg(2, 1, 5, 2, 0, 2);
    enable[2] = 1'b1;
    run_cycles(1);
    trigger[2] = 1'b1;
    clr_stats();
    run_cycles(3);
    trigger[2] = 1'b0;
    run_cycles(1);
    trigger[2] = 1'b1;
    run_cycles(16);
    check("retrig_rises", 32'(rise_cnt[2]), 32'd2);
    check("retrig_hi", 32'(hi_cnt[2]), 32'd4);
    check("retrig_done", 32'(done_cnt[2]), 32'd1);
    trigger[2] = 1'b0;
    enable[2] = 1'b0;
    run_cycles(2);

    // gate dropped mid-pulse finishes the current period
    set_cfg(3, 2, 7, 4, 0, 0);
    enable[3] = 1'b1;
    trigger[3] = 1'b1;
    clr_stats();
    run_cycles(10);
    trigger[3] = 1'b0;
    run_cycles(15);
    check("gate_hi", 32'(hi_cnt[3]), 32'd8);
    check("gate_rises", 32'(rise_cnt[3]), 32'd2);
    check("gate_done", 32'(done_cnt[3]), 32'd0);
    check("gate_busy_end", 32'(last_busy[3]), 32'd16);
    enable[3] = 1'b0;
    run_cycles(2);

    // abort, enable drop and async reset while high
    set_cfg(0, 0, 9, 3, 0, 0);
    enable[0] = 1'b1;
    run_cycles(2);
    abort[0] = 1'b1;
    run_cycles(1);
    check("abort_dout", 32'(dout[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    abort[0] = 1'b0;
    run_cycles(5);
    enable[0] = 1'b0;
    run_cycles(1);
    check("dis_dout", 32'(dout[0]), 32'd0);
    enable[0] = 1'b1;
    run_cycles(2);
    async_reset_check("areset");
    run_cycles(5);
    enable[0] = 1'b0;
    run_cycles(2);

    // length=0 and length>period
    set_cfg(1, 0, 3, 0, 0, 2);
    set_cfg(2, 0, 3, 10, 0, 2);
    enable[1] = 1'b1;
    enable[2] = 1'b1;
    clr_stats();
    run_cycles(9);
    check("len0_hi", 32'(hi_cnt[1]), 32'd0);
    check("len0_done", 32'(done_cnt[1]), 32'd1);
    check("lenbig_hi", 32'(hi_cnt[2]), 32'd8);
    check("lenbig_rises", 32'(rise_cnt[2]), 32'd1);
    check("lenbig_done", 32'(done_cnt[2]), 32'd1);
    enable = '0;
    run_cycles(2);

    // randomized concurrent traffic on all channels
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < N_CH; c++)
        set_cfg(c, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 15),
                $urandom_range(0, 6), $urandom_range(0, 4));
      enable = '1;
      if (blk == 3) async_reset_check("rand_reset");
      for (int cyc = 0; cyc < 200; cyc++) begin
        for (int c = 0; c < N_CH; c++) begin
          if ($urandom_range(0, 5) == 0) trigger[c] = ~trigger[c];
          abort[c]  = ($urandom_range(0, 79) == 0);
          enable[c] = ($urandom_range(0, 119) != 0);
          if ($urandom_range(0, 39) == 0)
            set_cfg(c, int'(mode[2*c +: 2]), $urandom_range(0, 12), $urandom_range(0, 15),
                    $urandom_range(0, 6), $urandom_range(0, 4));
        end
        run_cycles(1);
      end
      abort = '0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
